// File: rtl/rx_pkg.sv
// Shared receive-chain definitions: peak-detector FSM encoding and the default
// sample/timestamp widths that match rx_filter's output.
package rx_pkg;

    localparam int RX_DATA_W = 32;
    localparam int RX_TS_W   = 24;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_WINDOW  = 2'd1,
        ST_HOLDOFF = 2'd2
    } pk_state_e;

endpackage

// File: rtl/rx_abs_reg.sv
// Registered magnitude stage: |sample| as an unsigned word, with the sample tag
// and valid bit travelling alongside so stage 2 sees them aligned.
module rx_abs_reg #(
    parameter int DATA_W = 32,
    parameter int TS_W   = 24
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     valid_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic [TS_W-1:0]          tag_i,
    output logic [DATA_W-1:0]        mag_o,
    output logic [TS_W-1:0]          tag_o,
    output logic                     valid_o
);

    logic [DATA_W-1:0] mag_q, mag_d;
    logic [TS_W-1:0]   tag_q, tag_d;
    logic              valid_q, valid_d;

    // Negating the most negative value wraps to the same bit pattern, which read
    // as unsigned is exactly 2^(DATA_W-1), so no saturation is required.
    always_comb begin
        mag_d   = mag_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        if (en_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                mag_d = sample_i[DATA_W-1] ? DATA_W'(-sample_i) : DATA_W'(sample_i);
                tag_d = tag_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mag_q   <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            mag_q   <= mag_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end

    assign mag_o   = mag_q;
    assign tag_o   = tag_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/rx_peak_detector.sv
// Finds the largest-magnitude sample in a window opened by a threshold crossing,
// reports its magnitude and timestamp, then holds off for a number of samples.
module rx_peak_detector
    import rx_pkg::*;
#(
    parameter int DATA_W  = RX_DATA_W,
    parameter int TS_W    = RX_TS_W,
    parameter int WIN_LEN = 64,
    parameter int HOLDOFF = 256
) (
    input  logic                     crx_clk,
    input  logic                     rrx_rst,
    input  logic                     erx_en,
    input  logic signed [DATA_W-1:0] isample,
    input  logic                     inew_sample,
    input  logic [DATA_W-1:0]        ithreshold,
    input  logic                     iclear,
    output logic [DATA_W-1:0]        opeak_mag,
    output logic [TS_W-1:0]          opeak_ts,
    output logic                     opeak_ready_trig,
    output logic                     obusy,
    output pk_state_e                odbg_state
);

    localparam int WC_W = $clog2(WIN_LEN + 1);
    localparam int HC_W = $clog2(HOLDOFF + 2);

    logic [TS_W-1:0]   sc_q, sc_d;
    logic [DATA_W-1:0] s1_mag;
    logic [TS_W-1:0]   s1_tag;
    logic              s1_valid;

    pk_state_e         state_q, state_d;
    logic [DATA_W-1:0] best_mag_q, best_mag_d;
    logic [TS_W-1:0]   best_ts_q, best_ts_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [HC_W-1:0]   hcnt_q, hcnt_d;
    logic              rep_pend_q, rep_pend_d;
    logic [DATA_W-1:0] peak_mag_q, peak_mag_d;
    logic [TS_W-1:0]   peak_ts_q, peak_ts_d;
    logic              trig_q, trig_d;
    logic              close_c;

    assign sc_d = (erx_en && inew_sample) ? sc_q + TS_W'(1) : sc_q;

    rx_abs_reg #(.DATA_W(DATA_W), .TS_W(TS_W)) u_abs (
        .clk_i    (crx_clk),
        .rst_ni   (rrx_rst),
        .en_i     (erx_en),
        .valid_i  (inew_sample),
        .sample_i (isample),
        .tag_i    (sc_q),
        .mag_o    (s1_mag),
        .tag_o    (s1_tag),
        .valid_o  (s1_valid)
    );

    // A closing window only arms rep_pend; the output registers load one edge
    // later from best_*, which still hold the closing values at that point.
    always_comb begin
        state_d    = state_q;
        best_mag_d = best_mag_q;
        best_ts_d  = best_ts_q;
        wcnt_d     = wcnt_q;
        hcnt_d     = hcnt_q;
        rep_pend_d = rep_pend_q;
        peak_mag_d = peak_mag_q;
        peak_ts_d  = peak_ts_q;
        trig_d     = trig_q;
        close_c    = 1'b0;
        if (erx_en) begin
            trig_d     = rep_pend_q;
            rep_pend_d = 1'b0;
            if (rep_pend_q) begin
                peak_mag_d = best_mag_q;
                peak_ts_d  = best_ts_q;
            end
            if (iclear) begin
                state_d    = ST_SEARCH;
                best_mag_d = '0;
                best_ts_d  = '0;
                wcnt_d     = '0;
                hcnt_d     = '0;
            end else if (s1_valid) begin
                case (state_q)
                    ST_SEARCH: begin
                        if (s1_mag > ithreshold) begin
                            best_mag_d = s1_mag;
                            best_ts_d  = s1_tag;
                            wcnt_d     = WC_W'(1);
                            if (WIN_LEN == 1) close_c = 1'b1;
                            else              state_d = ST_WINDOW;
                        end
                    end
                    ST_WINDOW: begin
                        if (s1_mag > best_mag_q) begin
                            best_mag_d = s1_mag;
                            best_ts_d  = s1_tag;
                        end
                        wcnt_d = wcnt_q + WC_W'(1);
                        if (wcnt_d == WC_W'(WIN_LEN)) close_c = 1'b1;
                    end
                    ST_HOLDOFF: begin
                        hcnt_d = hcnt_q + HC_W'(1);
                        if (hcnt_d == HC_W'(HOLDOFF)) state_d = ST_SEARCH;
                    end
                    default: state_d = ST_SEARCH;
                endcase
                if (close_c) begin
                    rep_pend_d = 1'b1;
                    hcnt_d     = '0;
                    state_d    = (HOLDOFF == 0) ? ST_SEARCH : ST_HOLDOFF;
                end
            end
        end
    end

    always_ff @(posedge crx_clk or negedge rrx_rst) begin
        if (!rrx_rst) begin
            sc_q       <= '0;
            state_q    <= ST_SEARCH;
            best_mag_q <= '0;
            best_ts_q  <= '0;
            wcnt_q     <= '0;
            hcnt_q     <= '0;
            rep_pend_q <= 1'b0;
            peak_mag_q <= '0;
            peak_ts_q  <= '0;
            trig_q     <= 1'b0;
        end else begin
            sc_q       <= sc_d;
            state_q    <= state_d;
            best_mag_q <= best_mag_d;
            best_ts_q  <= best_ts_d;
            wcnt_q     <= wcnt_d;
            hcnt_q     <= hcnt_d;
            rep_pend_q <= rep_pend_d;
            peak_mag_q <= peak_mag_d;
            peak_ts_q  <= peak_ts_d;
            trig_q     <= trig_d;
        end
    end

    assign opeak_mag        = peak_mag_q;
    assign opeak_ts         = peak_ts_q;
    assign opeak_ready_trig = trig_q;
    assign obusy            = (state_q == ST_WINDOW) || (state_q == ST_HOLDOFF);
    assign odbg_state       = state_q;

endmodule

// File: tb/tb_rx_peak_detector.sv
// Directed bench for rx_peak_detector with WIN_LEN=4, HOLDOFF=8.
module tb_rx_peak_detector;
    import rx_pkg::*;

    localparam int DATA_W = 32;
    localparam int TS_W   = 24;

    logic                     crx_clk;
    logic                     rrx_rst;
    logic                     erx_en;
    logic signed [DATA_W-1:0] isample;
    logic                     inew_sample;
    logic [DATA_W-1:0]        ithreshold;
    logic                     iclear;
    logic [DATA_W-1:0]        opeak_mag;
    logic [TS_W-1:0]          opeak_ts;
    logic                     opeak_ready_trig;
    logic                     obusy;
    pk_state_e                odbg_state;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int trig_cnt = 0;
    int trig_cyc = 0;
    int acc_cyc  = 0;

    rx_peak_detector #(
        .DATA_W(DATA_W), .TS_W(TS_W), .WIN_LEN(4), .HOLDOFF(8)
    ) dut (
        .crx_clk          (crx_clk),
        .rrx_rst          (rrx_rst),
        .erx_en           (erx_en),
        .isample          (isample),
        .inew_sample      (inew_sample),
        .ithreshold       (ithreshold),
        .iclear           (iclear),
        .opeak_mag        (opeak_mag),
        .opeak_ts         (opeak_ts),
        .opeak_ready_trig (opeak_ready_trig),
        .obusy            (obusy),
        .odbg_state       (odbg_state)
    );

    initial crx_clk = 1'b0;
    always #5 crx_clk = ~crx_clk;

    always @(posedge crx_clk) cyc <= cyc + 1;

    always @(negedge crx_clk) begin
        if (opeak_ready_trig === 1'b1) begin
            trig_cnt = trig_cnt + 1;
            trig_cyc = cyc;
        end
    end

    task automatic do_reset();
        rrx_rst     = 1'b0;
        inew_sample = 1'b0;
        iclear      = 1'b0;
        isample     = '0;
        repeat (2) @(negedge crx_clk);
        rrx_rst = 1'b1;
        @(negedge crx_clk);
        #1;
    endtask

    task automatic strobe(input logic signed [DATA_W-1:0] s);
        isample     = s;
        inew_sample = 1'b1;
        @(negedge crx_clk);
        acc_cyc     = cyc;
        inew_sample = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge crx_clk);
        #1;
    endtask

    task automatic test_reset();
        rrx_rst = 1'b0;
        #3;
        n_chk++; if (opeak_mag !== '0) $display("FAIL reset_mag: got %0d want 0", opeak_mag); else n_pass++;
        n_chk++; if (opeak_ts !== '0) $display("FAIL reset_ts: got %0d want 0", opeak_ts); else n_pass++;
        n_chk++; if (opeak_ready_trig !== 1'b0) $display("FAIL reset_trig: got %b want 0", opeak_ready_trig); else n_pass++;
        n_chk++; if (obusy !== 1'b0) $display("FAIL reset_busy: got %b want 0", obusy); else n_pass++;
        n_chk++; if (odbg_state !== ST_SEARCH) $display("FAIL reset_state: got %0d want %0d", odbg_state, ST_SEARCH); else n_pass++;
        do_reset();
    endtask

    task automatic test_no_cross();
        int base;
        do_reset();
        ithreshold = 32'd100;
        base = trig_cnt;
        for (int i = 0; i < 10; i++) strobe(32'sd5);
        idle(4);
        n_chk++; if (trig_cnt != base) $display("FAIL nocross_trig: got %0d want %0d", trig_cnt - base, 0); else n_pass++;
        n_chk++; if (obusy !== 1'b0) $display("FAIL nocross_busy: got %b want 0", obusy); else n_pass++;
        strobe(32'sd500); strobe(32'sd1); strobe(32'sd1); strobe(32'sd1);
        idle(4);
        n_chk++; if (trig_cnt != base + 1) $display("FAIL nocross_rep: got %0d want 1", trig_cnt - base); else n_pass++;
        n_chk++; if (opeak_ts !== 24'd10) $display("FAIL nocross_ts: got %0d want 10", opeak_ts); else n_pass++;
        n_chk++; if (opeak_mag !== 32'd500) $display("FAIL nocross_mag: got %0d want 500", opeak_mag); else n_pass++;
    endtask

    task automatic test_window();
        int base;
        do_reset();
        ithreshold = 32'd100;
        base = trig_cnt;
        strobe(32'sd0); strobe(32'sd0); strobe(32'sd150); strobe(-32'sd300);
        n_chk++; if (obusy !== 1'b1) $display("FAIL window_busy: got %b want 1", obusy); else n_pass++;
        strobe(32'sd200); strobe(32'sd50);
        idle(4);
        n_chk++; if (trig_cnt != base + 1) $display("FAIL window_count: got %0d want 1", trig_cnt - base); else n_pass++;
        n_chk++; if (opeak_mag !== 32'd300) $display("FAIL window_mag: got %0d want 300", opeak_mag); else n_pass++;
        n_chk++; if (opeak_ts !== 24'd3) $display("FAIL window_ts: got %0d want 3", opeak_ts); else n_pass++;
        n_chk++; if (trig_cyc - acc_cyc != 2) $display("FAIL window_latency: got %0d want 2", trig_cyc - acc_cyc); else n_pass++;
        n_chk++; if (odbg_state !== ST_HOLDOFF) $display("FAIL window_holdoff: got %0d want %0d", odbg_state, ST_HOLDOFF); else n_pass++;
    endtask

    task automatic test_tie();
        int base;
        do_reset();
        ithreshold = 32'd100;
        base = trig_cnt;
        strobe(32'sd150); strobe(32'sd300); strobe(-32'sd300); strobe(32'sd10);
        idle(4);
        n_chk++; if (trig_cnt != base + 1) $display("FAIL tie_count: got %0d want 1", trig_cnt - base); else n_pass++;
        n_chk++; if (opeak_mag !== 32'd300) $display("FAIL tie_mag: got %0d want 300", opeak_mag); else n_pass++;
        n_chk++; if (opeak_ts !== 24'd1) $display("FAIL tie_ts: got %0d want 1", opeak_ts); else n_pass++;
    endtask

    task automatic test_min_neg();
        int base;
        do_reset();
        ithreshold = 32'd0;
        base = trig_cnt;
        strobe(32'sh8000_0000); strobe(32'sd0); strobe(32'sd0); strobe(32'sd0);
        idle(4);
        n_chk++; if (trig_cnt != base + 1) $display("FAIL minneg_count: got %0d want 1", trig_cnt - base); else n_pass++;
        n_chk++; if (opeak_mag !== 32'h8000_0000) $display("FAIL minneg_mag: got %h want 80000000", opeak_mag); else n_pass++;
        n_chk++; if (opeak_ts !== 24'd0) $display("FAIL minneg_ts: got %0d want 0", opeak_ts); else n_pass++;
    endtask

    task automatic test_holdoff();
        int base;
        do_reset();
        ithreshold = 32'd100;
        base = trig_cnt;
        strobe(32'sd500); strobe(32'sd1); strobe(32'sd1); strobe(32'sd1);
        for (int i = 0; i < 8; i++) strobe(32'sd1000);
        idle(1);
        n_chk++; if (trig_cnt != base + 1) $display("FAIL holdoff_count: got %0d want 1", trig_cnt - base); else n_pass++;
        n_chk++; if (obusy !== 1'b0) $display("FAIL holdoff_release: got %b want 0", obusy); else n_pass++;
        strobe(32'sd1000);
        idle(1);
        n_chk++; if (obusy !== 1'b1) $display("FAIL holdoff_reopen: got %b want 1", obusy); else n_pass++;
        strobe(32'sd1); strobe(32'sd1); strobe(32'sd1);
        idle(4);
        n_chk++; if (trig_cnt != base + 2) $display("FAIL holdoff_second: got %0d want 2", trig_cnt - base); else n_pass++;
        n_chk++; if (opeak_mag !== 32'd1000) $display("FAIL holdoff_mag: got %0d want 1000", opeak_mag); else n_pass++;
        n_chk++; if (opeak_ts !== 24'd12) $display("FAIL holdoff_ts: got %0d want 12", opeak_ts); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        ithreshold = 32'd100;
        base = trig_cnt;
        strobe(32'sd500); strobe(32'sd600);
        n_chk++; if (obusy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", obusy); else n_pass++;
        #2 rrx_rst = 1'b0;
        #1;
        n_chk++; if (obusy !== 1'b0) $display("FAIL rstmid_busy_after: got %b want 0", obusy); else n_pass++;
        @(negedge crx_clk);
        rrx_rst = 1'b1;
        idle(6);
        n_chk++; if (trig_cnt != base) $display("FAIL rstmid_norep: got %0d want 0", trig_cnt - base); else n_pass++;
        strobe(32'sd700); strobe(32'sd1); strobe(32'sd1); strobe(32'sd1);
        idle(4);
        n_chk++; if (opeak_ts !== 24'd0) $display("FAIL rstmid_ts: got %0d want 0", opeak_ts); else n_pass++;
        n_chk++; if (opeak_mag !== 32'd700) $display("FAIL rstmid_mag: got %0d want 700", opeak_mag); else n_pass++;
    endtask

    task automatic test_clear_mid();
        int base;
        do_reset();
        ithreshold = 32'd100;
        base = trig_cnt;
        strobe(32'sd500); strobe(32'sd600);
        iclear = 1'b1;
        @(negedge crx_clk);
        iclear = 1'b0;
        #1;
        n_chk++; if (obusy !== 1'b0) $display("FAIL clear_busy: got %b want 0", obusy); else n_pass++;
        idle(6);
        n_chk++; if (trig_cnt != base) $display("FAIL clear_norep: got %0d want 0", trig_cnt - base); else n_pass++;
        strobe(32'sd800); strobe(32'sd1); strobe(32'sd1); strobe(32'sd1);
        idle(4);
        n_chk++; if (trig_cnt != base + 1) $display("FAIL clear_rep: got %0d want 1", trig_cnt - base); else n_pass++;
        n_chk++; if (opeak_ts !== 24'd2) $display("FAIL clear_ts: got %0d want 2", opeak_ts); else n_pass++;
        n_chk++; if (opeak_mag !== 32'd800) $display("FAIL clear_mag: got %0d want 800", opeak_mag); else n_pass++;
    endtask

    initial begin
        rrx_rst     = 1'b0;
        erx_en      = 1'b1;
        isample     = '0;
        inew_sample = 1'b0;
        ithreshold  = 32'd100;
        iclear      = 1'b0;
        test_reset();
        test_no_cross();
        test_window();
        test_tie();
        test_min_neg();
        test_holdoff();
        test_reset_mid();
        test_clear_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rx_peak_detector.md
Name: rx_peak_detector

Overview:
- Downstream stage of rx_filter: consumes each filtered correlation sample and its ready trigger.
- Finds the largest-magnitude sample within a search window opened by a threshold crossing.
- Reports that sample's magnitude and its sample-count timestamp to the time-of-arrival logic.
- After each report, applies a holdoff so filter sidelobes and multipath echoes do not produce extra reports.

Parameters:
- DATA_W, 32: width of the signed filtered sample.
- TS_W, 24: width of the sample counter / timestamp.
- WIN_LEN, 64: search window length in accepted samples, counting the crossing sample; must be ≥1.
- HOLDOFF, 256: samples ignored after a report; 0 means no holdoff.

Ports:
- crx_clk, in, 1: receive clock; all logic on the rising edge.
- rrx_rst, in, 1: reset, asynchronous, active-low.
- erx_en, in, 1: block enable.
- isample, in, DATA_W: signed filtered sample from rx_filter.
- inew_sample, in, 1: one-cycle strobe; isample is valid this cycle.
- ithreshold, in, DATA_W: unsigned detection threshold; held static.
- iclear, in, 1: synchronous abort back to SEARCH.
- opeak_mag, out, DATA_W: unsigned magnitude of the reported peak.
- opeak_ts, out, TS_W: sample-counter value of the reported peak.
- opeak_ready_trig, out, 1: one-cycle strobe; opeak_mag and opeak_ts are valid.
- obusy, out, 1: high in WINDOW or HOLDOFF.

Behaviour:
- Accept: a sample is accepted on an edge where rrx_rst=1, erx_en=1 and inew_sample=1.
- erx_en=0: strobes are ignored; FSM, counters and outputs are frozen.
- Sample counter sc:
  - reset 0; increments by 1 per accepted sample, modulo 2^TS_W.
  - Each accepted sample is tagged with the pre-increment sc (first sample after reset has ts 0).
  - Not affected by iclear.
- Stage 1 (registered): mag = |isample| as DATA_W unsigned.
  - -2^(DATA_W-1) maps to 2^(DATA_W-1) exactly (no saturation is needed).
  - Tag and valid travel with mag.
- Stage 2, FSM update on the edge after stage 1:
  - SEARCH: if mag > ithreshold (strict): best_mag=mag, best_ts=tag, wcnt=1.
    - If WIN_LEN=1, report now; otherwise go to WINDOW.
  - WINDOW, per valid sample:
    - If mag > best_mag (strict), update best_mag and best_ts; ties keep the earlier sample.
    - wcnt++. When wcnt reaches WIN_LEN, report.
  - Report: load opeak_mag/opeak_ts and pulse opeak_ready_trig for exactly one cycle.
    - Then go to HOLDOFF with hcnt=0, or to SEARCH if HOLDOFF=0.
  - HOLDOFF: valid samples increment hcnt; at hcnt==HOLDOFF go to SEARCH. Samples are not compared.
- Latency: opeak_ready_trig is high during the cycle after the 2nd rising edge following the accepting edge of the window-closing sample.
- Back-to-back strobes on consecutive cycles are supported; the pipeline never stalls.
- iclear:
  - In the same cycle as a valid stage-2 sample, iclear wins: FSM goes to SEARCH, wcnt/hcnt/best_* are cleared, the sample is discarded and no report is made.
  - The stage-1 register is not flushed.
- Reset values: opeak_mag=0, opeak_ts=0, opeak_ready_trig=0, obusy=0, FSM=SEARCH, sc=0, stage-1 valid=0.
- Reset mid-window: everything returns to reset values immediately; no partial report.
- Timestamp wrap: timestamps wrap silently; no flag is raised.
- opeak_mag and opeak_ts hold their last values until the next report.

Decomposition:
- Shared package rx_pkg:
  - FSM state encoding (SEARCH, WINDOW, HOLDOFF).
  - Default DATA_W/TS_W constants shared with rx_filter's output width.
- One sub-module, rx_abs_reg: a registered signed-to-unsigned magnitude stage with a passthrough tag/valid.

Test Plan:
- Reset, then 10 strobes of isample=5 with threshold 100 -> no opeak_ready_trig; obusy=0; next tag = 10.
- Threshold 100, WIN_LEN 4; samples 0,0,150,-300,200,50 (ts 0..5) -> one pulse, opeak_mag=300, opeak_ts=3, 2 cycles after the ts-5 strobe.
- Tie case: samples 150,300,-300,10 with WIN_LEN 4 -> opeak_ts = ts of the first 300.
- isample=-2^31, DATA_W 32, threshold 0 -> opeak_mag=32'h8000_0000.
- HOLDOFF 8: a peak, then 8 samples of 1000 -> no second report; the 9th sample of 1000 opens a new window.
- rrx_rst pulsed low mid-WINDOW, and separately iclear asserted mid-WINDOW -> no report, obusy drops; in the reset case sc=0; in the iclear case sc continues.
